// File: rtl/l1_cache_pkg.sv
// Shared types and sizing helpers for the L1 data array and its per-way banks.
// Optional parity storage is enabled with the DATA_ARRAY_PARITY_EN macro.
package l1_cache_pkg;

    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_t;

    localparam int BYTE_W = 8;

    function automatic int mask_w_f(input int s_offset);
        return 1 << s_offset;
    endfunction

    function automatic int line_bits_f(input int s_offset);
        return BYTE_W * (1 << s_offset);
    endfunction

    function automatic int beat_count_f(input int s_offset, input int beat_w);
        return line_bits_f(s_offset) / beat_w;
    endfunction

    function automatic int cnt_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/l1_data_array_nway_data_way_bank.sv
// One way of the data array: two byte-masked write ports (CPU has priority
// over fill), combinational read, optional per-byte parity (DATA_ARRAY_PARITY_EN).
module data_way_bank
    import l1_cache_pkg::*;
#(
    parameter  int S_OFFSET  = 5,
    parameter  int S_INDEX   = 3,
    localparam int MASK_W    = mask_w_f(S_OFFSET),
    localparam int LINE_BITS = line_bits_f(S_OFFSET)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MASK_W-1:0]    cpu_mask_i,
    input  logic [S_INDEX-1:0]   cpu_index_i,
    input  logic [LINE_BITS-1:0] cpu_data_i,
    input  logic [MASK_W-1:0]    fill_mask_i,
    input  logic [S_INDEX-1:0]   fill_index_i,
    input  logic [LINE_BITS-1:0] fill_data_i,
    input  logic [S_INDEX-1:0]   rd_index_i,
    output logic [LINE_BITS-1:0] rd_data_o
`ifdef DATA_ARRAY_PARITY_EN
   ,output logic [MASK_W-1:0]    rd_par_o
`endif
);

    localparam int SETS = 1 << S_INDEX;

    logic [LINE_BITS-1:0] mem_q [SETS];
`ifdef DATA_ARRAY_PARITY_EN
    logic [SETS-1:0][MASK_W-1:0] par_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is reset on purpose so an abandoned fill leaves no partial line behind.
            for (int s = 0; s < SETS; s++) begin
                mem_q[s] <= '0;
`ifdef DATA_ARRAY_PARITY_EN
                par_q[s] <= '0;
`endif
            end
        end else begin
            // NOTE: state uses non-blocking assignments so all banks and the FSM see pre-edge values.
            for (int s = 0; s < SETS; s++) begin
                for (int b = 0; b < MASK_W; b++) begin
                    if (cpu_mask_i[b] && cpu_index_i == S_INDEX'(s)) begin
                        mem_q[s][b*BYTE_W +: BYTE_W] <= cpu_data_i[b*BYTE_W +: BYTE_W];
`ifdef DATA_ARRAY_PARITY_EN
                        par_q[s][b] <= ^cpu_data_i[b*BYTE_W +: BYTE_W];
`endif
                    end else if (fill_mask_i[b] && fill_index_i == S_INDEX'(s)) begin
                        mem_q[s][b*BYTE_W +: BYTE_W] <= fill_data_i[b*BYTE_W +: BYTE_W];
`ifdef DATA_ARRAY_PARITY_EN
                        par_q[s][b] <= ^fill_data_i[b*BYTE_W +: BYTE_W];
`endif
                    end
                end
            end
        end
    end

    assign rd_data_o = mem_q[rd_index_i];
`ifdef DATA_ARRAY_PARITY_EN
    assign rd_par_o  = par_q[rd_index_i];
`endif

endmodule

// File: rtl/l1_data_array_nway.sv
// N-way L1 data store: CPU byte-masked write, registered read with write
// forwarding, and a burst line-fill engine. Parity via DATA_ARRAY_PARITY_EN.
module l1_data_array_nway
    import l1_cache_pkg::*;
#(
    parameter  int S_OFFSET  = 5,
    parameter  int S_INDEX   = 3,
    parameter  int NUM_WAYS  = 2,
    parameter  int BEAT_W    = 64,
    localparam int MASK_W    = mask_w_f(S_OFFSET),
    localparam int LINE_BITS = line_bits_f(S_OFFSET),
    localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic [S_INDEX-1:0]   rd_index,
    input  logic [WAY_W-1:0]     rd_way,
    output logic [LINE_BITS-1:0] rd_data,
    output logic                 rd_valid,
    input  logic [MASK_W-1:0]    wr_mask,
    input  logic [S_INDEX-1:0]   wr_index,
    input  logic [WAY_W-1:0]     wr_way,
    input  logic [LINE_BITS-1:0] wr_data,
    input  logic                 fill_start,
    input  logic [S_INDEX-1:0]   fill_index,
    input  logic [WAY_W-1:0]     fill_way,
    input  logic                 fill_beat_valid,
    input  logic [BEAT_W-1:0]    fill_beat_data,
    output logic                 fill_beat_ready,
    output logic                 fill_busy,
    output logic                 fill_done
`ifdef DATA_ARRAY_PARITY_EN
   ,output logic                 rd_parity_err
`endif
);

    localparam int BEATS      = beat_count_f(S_OFFSET, BEAT_W);
    localparam int CNT_W      = cnt_w_f(BEATS);
    localparam int BEAT_BYTES = BEAT_W / BYTE_W;

    fill_state_t          state_q;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic [S_INDEX-1:0]   fill_index_q;
    logic [WAY_W-1:0]     fill_way_q;
    logic                 ready_q, busy_q, done_q;
    logic [LINE_BITS-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q;

    logic                 beat_xfer;
    logic [MASK_W-1:0]    fill_mask, cpu_fwd, fill_fwd;
    logic [LINE_BITS-1:0] fill_line, rd_store;
    logic [LINE_BITS-1:0] bank_rd [NUM_WAYS];

    assign beat_xfer = (state_q == FILL) && fill_beat_valid;

    // Place the beat at its byte lanes; only lanes of the current beat are enabled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        fill_mask = '0;
        fill_line = '0;
        for (int b = 0; b < MASK_W; b++) begin
            fill_line[b*BYTE_W +: BYTE_W] = fill_beat_data[(b % BEAT_BYTES)*BYTE_W +: BYTE_W];
            fill_mask[b] = beat_xfer && (CNT_W'(b / BEAT_BYTES) == beat_cnt_q);
        end
    end

`ifdef DATA_ARRAY_PARITY_EN
    logic [MASK_W-1:0] bank_par [NUM_WAYS];
    logic [MASK_W-1:0] err_bits;
    logic              rd_parity_err_q;
`endif

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic [MASK_W-1:0] cpu_mask_w, fill_mask_w;
        assign cpu_mask_w  = (wr_way == WAY_W'(w)) ? wr_mask : '0;
        assign fill_mask_w = (fill_way_q == WAY_W'(w)) ? fill_mask : '0;

        data_way_bank #(.S_OFFSET(S_OFFSET), .S_INDEX(S_INDEX)) u_bank (
            .clk          (clk),
            .rst          (rst),
            .cpu_mask_i   (cpu_mask_w),
            .cpu_index_i  (wr_index),
            .cpu_data_i   (wr_data),
            .fill_mask_i  (fill_mask_w),
            .fill_index_i (fill_index_q),
            .fill_data_i  (fill_line),
            .rd_index_i   (rd_index),
            .rd_data_o    (bank_rd[w])
`ifdef DATA_ARRAY_PARITY_EN
           ,.rd_par_o     (bank_par[w])
`endif
        );
    end

    // Forwarding merge mirrors the bank write priority: CPU bytes, then fill bytes, then storage.
    always_comb begin
        rd_store  = bank_rd[rd_way];
        cpu_fwd   = (wr_way == rd_way && wr_index == rd_index) ? wr_mask : '0;
        fill_fwd  = (fill_way_q == rd_way && fill_index_q == rd_index) ? fill_mask : '0;
        rd_data_d = rd_store;
        for (int b = 0; b < MASK_W; b++) begin
            if (cpu_fwd[b])
                rd_data_d[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
            else if (fill_fwd[b])
                rd_data_d[b*BYTE_W +: BYTE_W] = fill_line[b*BYTE_W +: BYTE_W];
        end
    end

`ifdef DATA_ARRAY_PARITY_EN
    // Forwarded bytes carry freshly computed parity, so they can never flag an error.
    always_comb begin
        err_bits = '0;
        for (int b = 0; b < MASK_W; b++)
            err_bits[b] = !(cpu_fwd[b] || fill_fwd[b]) &&
                          ((^rd_store[b*BYTE_W +: BYTE_W]) != bank_par[rd_way][b]);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef DATA_ARRAY_PARITY_EN
            rd_parity_err_q <= 1'b0;
`endif
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_data_d;
`ifdef DATA_ARRAY_PARITY_EN
            rd_parity_err_q <= rd_en && (|err_bits);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            fill_index_q <= '0;
            fill_way_q   <= '0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (fill_start) begin
                    state_q      <= FILL;
                    beat_cnt_q   <= '0;
                    fill_index_q <= fill_index;
                    fill_way_q   <= fill_way;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b1;
                end
                FILL: if (beat_xfer) begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                    if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                        state_q <= DONE;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
    assign fill_beat_ready = ready_q;
    assign fill_busy       = busy_q;
    assign fill_done       = done_q;
`ifdef DATA_ARRAY_PARITY_EN
    assign rd_parity_err   = rd_parity_err_q;
`endif

endmodule
